// File: rtl/cook_timer_if.sv
// Keypad encoder link into the cook timer: BCD digit, digit strobe, 1 Hz tick.
// Ports: master drives D/loadn/pgt_1hz (encoder), slave receives them (timer).
interface cook_timer_if;
    logic [3:0] D;
    logic       loadn;
    logic       pgt_1hz;

    modport master (output D, loadn, pgt_1hz);
    modport slave  (input  D, loadn, pgt_1hz);
endinterface

// File: rtl/cook_timer.sv
// Microwave cook timer: BCD MM:SS entry, 1 Hz countdown, cook-cycle FSM.
// Ports: clk, resetn (async low), kp (encoder link), startn, stopn,
//   door_closed in; min_tens/min_ones/sec_tens/sec_ones, state,
//   magnetron_on, done out; beep out only when DONE_BEEP_EN is defined.
module cook_timer #(
    parameter int SYNC_STAGES   = 2,
    parameter int SEC_TENS_WRAP = 5,
    parameter int BEEP_TICKS    = 3
) (
    input  logic         clk,
    input  logic         resetn,
    cook_timer_if.slave  kp,
    input  logic         startn,
    input  logic         stopn,
    input  logic         door_closed,
    output logic [3:0]   min_tens,
    output logic [3:0]   min_ones,
    output logic [3:0]   sec_tens,
    output logic [3:0]   sec_ones,
    output logic [2:0]   state,
    output logic         magnetron_on,
`ifdef DONE_BEEP_EN
    output logic         beep,
`endif
    output logic         done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } st_t;

    localparam int TOP = SYNC_STAGES - 1;

    st_t cur;
    st_t n_state;

    logic [SYNC_STAGES-1:0] ld_s, st_s, sp_s, tk_s, dr_s;
    logic ld_q, st_q, sp_q, tk_q;
    logic ld_ev, st_ev, sp_ev, tk_ev, door;

    logic [3:0] n_mt, n_mo, n_st, n_so;
    logic [3:0] d_mt, d_mo, d_st, d_so;
    logic       b1, b2, b3, d_zero, nonzero;

    assign state = cur;

    // Sync chains idle at the inactive level so release of reset
    // never fabricates an edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ld_s <= '1;
            st_s <= '1;
            sp_s <= '1;
            tk_s <= '0;
            dr_s <= '0;
            ld_q <= 1'b1;
            st_q <= 1'b1;
            sp_q <= 1'b1;
            tk_q <= 1'b0;
        end else begin
            ld_s <= {ld_s[TOP-1:0], kp.loadn};
            st_s <= {st_s[TOP-1:0], startn};
            sp_s <= {sp_s[TOP-1:0], stopn};
            tk_s <= {tk_s[TOP-1:0], kp.pgt_1hz};
            dr_s <= {dr_s[TOP-1:0], door_closed};
            ld_q <= ld_s[TOP];
            st_q <= st_s[TOP];
            sp_q <= sp_s[TOP];
            tk_q <= tk_s[TOP];
        end
    end

    assign ld_ev = ld_q & ~ld_s[TOP];
    assign st_ev = st_q & ~st_s[TOP];
    assign sp_ev = sp_q & ~sp_s[TOP];
    assign tk_ev = ~tk_q & tk_s[TOP];
    assign door  = dr_s[TOP];

    // BCD borrow chain for one second of countdown.
    always_comb begin
        b1     = (sec_ones == 4'd0);
        d_so   = b1 ? 4'd9 : sec_ones - 4'd1;
        b2     = b1 && (sec_tens == 4'd0);
        d_st   = sec_tens;
        if (b1)
            d_st = (sec_tens == 4'd0) ? 4'(SEC_TENS_WRAP)
                                      : sec_tens - 4'd1;
        b3     = b2 && (min_ones == 4'd0);
        d_mo   = min_ones;
        if (b2)
            d_mo = (min_ones == 4'd0) ? 4'd9 : min_ones - 4'd1;
        d_mt   = b3 ? min_tens - 4'd1 : min_tens;
        d_zero = ({d_mt, d_mo, d_st, d_so} == 16'h0);
    end

    assign nonzero = |{min_tens, min_ones, sec_tens, sec_ones};

    // Priority: stop > door-open > start > tick > load.
    always_comb begin
        n_state = cur;
        n_mt    = min_tens;
        n_mo    = min_ones;
        n_st    = sec_tens;
        n_so    = sec_ones;
        if (sp_ev) begin
            if (cur == RUN) begin
                n_state = PAUSE;
            end else if (cur != IDLE) begin
                n_state = IDLE;
                n_mt    = 4'd0;
                n_mo    = 4'd0;
                n_st    = 4'd0;
                n_so    = 4'd0;
            end
        end else if (cur == RUN && !door) begin
            n_state = PAUSE;
        end else if (st_ev && (cur == ENTRY || cur == PAUSE)
                     && door && nonzero) begin
            n_state = RUN;
        end else if (tk_ev && cur == RUN) begin
            n_mt    = d_mt;
            n_mo    = d_mo;
            n_st    = d_st;
            n_so    = d_so;
            n_state = d_zero ? DONE : RUN;
        end else if (ld_ev && kp.D <= 4'd9
                     && (cur == IDLE || cur == ENTRY || cur == DONE)) begin
            n_state = ENTRY;
            // A finished cook starts a fresh entry rather than
            // appending to the stale 00:00.
            n_mt    = (cur == DONE) ? 4'd0 : min_ones;
            n_mo    = (cur == DONE) ? 4'd0 : sec_tens;
            n_st    = (cur == DONE) ? 4'd0 : sec_ones;
            n_so    = kp.D;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur          <= IDLE;
            min_tens     <= 4'd0;
            min_ones     <= 4'd0;
            sec_tens     <= 4'd0;
            sec_ones     <= 4'd0;
            magnetron_on <= 1'b0;
            done         <= 1'b0;
        end else begin
            cur          <= n_state;
            min_tens     <= n_mt;
            min_ones     <= n_mo;
            sec_tens     <= n_st;
            sec_ones     <= n_so;
            magnetron_on <= (n_state == RUN) && door;
            done         <= (n_state == DONE);
        end
    end

`ifdef DONE_BEEP_EN
    logic [1:0] bcnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beep <= 1'b0;
            bcnt <= 2'd0;
        end else if (n_state != DONE) begin
            beep <= 1'b0;
            bcnt <= 2'd0;
        end else if (cur != DONE) begin
            beep <= 1'b1;
            bcnt <= 2'd0;
        end else if (tk_ev && beep) begin
            if (bcnt == 2'(BEEP_TICKS - 1))
                beep <= 1'b0;
            else
                bcnt <= bcnt + 2'd1;
        end
    end
`endif

endmodule
